// File: rtl/null_former_pkg.sv
// null_former_pkg
//   Shared definitions for the null-former coefficient loader:
//   - default channel/tap/coefficient sizes tied to the CRPA_* defines
//   - loader FSM state encoding
//   - width helpers for counters and the weight RAM address
`ifndef CRPA_NCH
`define CRPA_NCH 4
`endif
`ifndef CRPA_NT
`define CRPA_NT 8
`endif
`ifndef CRPA_C_WIDTH
`define CRPA_C_WIDTH 16
`endif

package null_former_pkg;

  localparam int CRPA_NCH_DEF     = `CRPA_NCH;
  localparam int CRPA_NT_DEF      = `CRPA_NT;
  localparam int CRPA_C_WIDTH_DEF = `CRPA_C_WIDTH;
  localparam int NBANK_DEF        = 4;
  localparam int DIV_WIDTH_DEF    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ARM   = 2'd3
  } state_e;

  // Index width for n items; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Weight RAM address width covering every bank at full size.
  function automatic int addr_width(input int nbank, input int nch, input int nt);
    return clog2_min1(nbank * nch * nt);
  endfunction

endpackage

// File: rtl/null_coef_loader_coef_addr_gen.sv
// coef_addr_gen
//   Channel/tap counters plus bank-offset adder for the weight RAM reader.
//   Walks channel-major, taps ascending, and keeps a registered full-width
//   RAM address alongside the counters.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clr       : restart at (ch 0, tap 0) of bank `bank`
//   adv       : step to the next (ch, tap)
//   bank      : bank number, used only while clr is high
//   ch, tap   : current channel / tap (registered)
//   addr      : current RAM address (registered)
//   last      : current word is the final one of the bank
module coef_addr_gen
  import null_former_pkg::*;
#(
  parameter int NCH   = CRPA_NCH_DEF,
  parameter int NT    = CRPA_NT_DEF,
  parameter int NBANK = NBANK_DEF,
  localparam int BANK_W = clog2_min1(NBANK),
  localparam int CH_W   = clog2_min1(NCH),
  localparam int TAP_W  = clog2_min1(NT),
  localparam int ADDR_W = addr_width(NBANK, NCH, NT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              adv,
  input  logic [BANK_W-1:0] bank,
  output logic [CH_W-1:0]   ch,
  output logic [TAP_W-1:0]  tap,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [CH_W-1:0]   ch_q,   ch_d;
  logic [TAP_W-1:0]  tap_q,  tap_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // Next counter/address values: restart at a bank base or step one word.
  always_comb begin
    ch_d   = ch_q;
    tap_d  = tap_q;
    addr_d = addr_q;
    if (clr) begin
      ch_d   = {CH_W{1'b0}};
      tap_d  = {TAP_W{1'b0}};
      // Full-width multiply so the top bank ends at the last RAM word.
      addr_d = ADDR_W'(bank) * ADDR_W'(NCH * NT);
    end else if (adv) begin
      // Words of a bank are contiguous, so the address simply increments.
      addr_d = addr_q + ADDR_W'(1);
      if (tap_q == TAP_W'(NT - 1)) begin
        tap_d = {TAP_W{1'b0}};
        ch_d  = ch_q + CH_W'(1);
      end else begin
        tap_d = tap_q + TAP_W'(1);
      end
    end else begin
      ch_d   = ch_q;
      tap_d  = tap_q;
      addr_d = addr_q;
    end
  end

  // Counter and address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q   <= {CH_W{1'b0}};
      tap_q  <= {TAP_W{1'b0}};
      addr_q <= {ADDR_W{1'b0}};
    end else begin
      ch_q   <= ch_d;
      tap_q  <= tap_d;
      addr_q <= addr_d;
    end
  end

  assign ch   = ch_q;
  assign tap  = tap_q;
  assign addr = addr_q;
  assign last = (ch_q == CH_W'(NCH - 1)) && (tap_q == TAP_W'(NT - 1));

endmodule

// File: rtl/null_coef_loader.sv
// null_coef_loader
//   Loads one NCH x NT weight bank from the synchronous weight RAM into the
//   channel FIR shadow coefficient registers, then raises coef_mirr until a
//   data sample is valid so all FIRs and null_div switch on that sample.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : one-cycle load request (bank_sel, div_in sampled with it)
//   sample_valid    : data-path valid strobe, selects the commit sample
//   clr_err         : clears the sticky overrun flag
//   rd_en/rd_addr   : weight RAM read port, rd_data returns one cycle later
//   coef_we/ch/tap/data : FIR shadow coefficient write port
//   coef_mirr       : commit strobe to all channel FIRs
//   null_div        : active divider shift
//   busy, done      : FSM not idle / one-cycle commit-complete pulse
//   overrun         : sticky, a start arrived while busy
module null_coef_loader
  import null_former_pkg::*;
#(
  parameter int NCH       = CRPA_NCH_DEF,
  parameter int NT        = CRPA_NT_DEF,
  parameter int C_WIDTH   = CRPA_C_WIDTH_DEF,
  parameter int NBANK     = NBANK_DEF,
  parameter int DIV_WIDTH = DIV_WIDTH_DEF,
  localparam int BANK_W = clog2_min1(NBANK),
  localparam int CH_W   = clog2_min1(NCH),
  localparam int TAP_W  = clog2_min1(NT),
  localparam int ADDR_W = addr_width(NBANK, NCH, NT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BANK_W-1:0]    bank_sel,
  input  logic [DIV_WIDTH-1:0] div_in,
  input  logic                 sample_valid,
  input  logic                 clr_err,
  output logic                 rd_en,
  output logic [ADDR_W-1:0]    rd_addr,
  input  logic [C_WIDTH-1:0]   rd_data,
  output logic                 coef_we,
  output logic [CH_W-1:0]      coef_ch,
  output logic [TAP_W-1:0]     coef_tap,
  output logic [C_WIDTH-1:0]   coef_data,
  output logic                 coef_mirr,
  output logic [DIV_WIDTH-1:0] null_div,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun
);

  state_e               state_q, state_d;
  logic                 rd_en_q, rd_en_d;
  logic                 coef_we_q, coef_we_d;
  logic [CH_W-1:0]      coef_ch_q, coef_ch_d;
  logic [TAP_W-1:0]     coef_tap_q, coef_tap_d;
  logic                 coef_mirr_q, coef_mirr_d;
  logic                 done_q, done_d;
  logic [DIV_WIDTH-1:0] null_div_q, null_div_d;
  logic [DIV_WIDTH-1:0] div_lat_q, div_lat_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q, busy_d;

  logic                 gen_clr;
  logic                 gen_adv;
  logic [CH_W-1:0]      gen_ch;
  logic [TAP_W-1:0]     gen_tap;
  logic                 gen_last;

  // The bank base is captured by the address generator on the start cycle.
  coef_addr_gen #(
    .NCH   (NCH),
    .NT    (NT),
    .NBANK (NBANK)
  ) u_addr_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (gen_clr),
    .adv  (gen_adv),
    .bank (bank_sel),
    .ch   (gen_ch),
    .tap  (gen_tap),
    .addr (rd_addr),
    .last (gen_last)
  );

  // Sequencer next state: read the bank, drain the RAM pipe, arm the commit.
  always_comb begin
    state_d     = state_q;
    rd_en_d     = 1'b0;
    coef_mirr_d = 1'b0;
    done_d      = 1'b0;
    null_div_d  = null_div_q;
    div_lat_d   = div_lat_q;
    gen_clr     = 1'b0;
    gen_adv     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_READ;
          rd_en_d   = 1'b1;
          gen_clr   = 1'b1;
          div_lat_d = div_in;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        // The word at the current counters is being issued this cycle.
        if (gen_last) begin
          state_d = ST_DRAIN;
        end else begin
          rd_en_d = 1'b1;
          gen_adv = 1'b1;
        end
      end
      ST_DRAIN: begin
        state_d     = ST_ARM;
        coef_mirr_d = 1'b1;
      end
      ST_ARM: begin
        // The valid cycle seen with coef_mirr high is the commit sample.
        if (sample_valid) begin
          state_d    = ST_IDLE;
          done_d     = 1'b1;
          null_div_d = div_lat_q;
        end else begin
          coef_mirr_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Write port lags the read side by the RAM latency; overrun and busy flags.
  always_comb begin
    coef_we_d  = rd_en_q;
    coef_ch_d  = gen_ch;
    coef_tap_d = gen_tap;
    busy_d     = (state_d != ST_IDLE);
    // A rejected start outranks a simultaneous clear.
    if (start && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end else if (clr_err) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Sequencer and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rd_en_q     <= 1'b0;
      coef_we_q   <= 1'b0;
      coef_ch_q   <= {CH_W{1'b0}};
      coef_tap_q  <= {TAP_W{1'b0}};
      coef_mirr_q <= 1'b0;
      done_q      <= 1'b0;
      null_div_q  <= {DIV_WIDTH{1'b0}};
      div_lat_q   <= {DIV_WIDTH{1'b0}};
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_en_q     <= rd_en_d;
      coef_we_q   <= coef_we_d;
      coef_ch_q   <= coef_ch_d;
      coef_tap_q  <= coef_tap_d;
      coef_mirr_q <= coef_mirr_d;
      done_q      <= done_d;
      null_div_q  <= null_div_d;
      div_lat_q   <= div_lat_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign rd_en     = rd_en_q;
  assign coef_we   = coef_we_q;
  assign coef_ch   = coef_ch_q;
  assign coef_tap  = coef_tap_q;
  // rd_data is the RAM's registered output; gating keeps the bus at zero
  // whenever no write is in flight.
  assign coef_data = coef_we_q ? rd_data : {C_WIDTH{1'b0}};
  assign coef_mirr = coef_mirr_q;
  assign null_div  = null_div_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_null_coef_loader.sv
module tb_null_coef_loader;

  localparam int NCH = 4;
  localparam int NT  = 8;
  localparam int NW  = NCH * NT;
  localparam int LIM = 120;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  bank_sel;
  logic [7:0]  div_in;
  logic        sample_valid;
  logic        clr_err;
  logic        rd_en;
  logic [6:0]  rd_addr;
  logic [15:0] rd_data = 16'h0000;
  logic        coef_we;
  logic [1:0]  coef_ch;
  logic [2:0]  coef_tap;
  logic [15:0] coef_data;
  logic        coef_mirr;
  logic [7:0]  null_div;
  logic        busy;
  logic        done;
  logic        overrun;

  null_coef_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bank_sel     (bank_sel),
    .div_in       (div_in),
    .sample_valid (sample_valid),
    .clr_err      (clr_err),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .coef_we      (coef_we),
    .coef_ch      (coef_ch),
    .coef_tap     (coef_tap),
    .coef_data    (coef_data),
    .coef_mirr    (coef_mirr),
    .null_div     (null_div),
    .busy         (busy),
    .done         (done),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // Weight RAM: synchronous, one-cycle read latency.
  logic [15:0] mem [0:127];
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  int n_cmp = 0;
  int n_err = 0;
  int p = 0;            // index of the current clock period
  logic [7:0] exp_div;  // model of the active divider

  // Observation log for one load.
  int n_rd, rd_first, rd_last, n_we, we_first, we_last;
  int n_mirr, mirr_first, mirr_last, n_done, done_at;
  logic [7:0]  div_at_mirr;
  logic        busy_at_done;
  logic [6:0]  addr_log [$];
  logic [20:0] wr_log [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    n_rd = 0; rd_first = -1; rd_last = -1;
    n_we = 0; we_first = -1; we_last = -1;
    n_mirr = 0; mirr_first = -1; mirr_last = -1;
    n_done = 0; done_at = -1;
    div_at_mirr = 8'hxx; busy_at_done = 1'bx;
    addr_log.delete();
    wr_log.delete();
  endtask

  // Advance one period and record outputs 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    p++;
    if (rd_en) begin
      if (n_rd == 0) rd_first = p;
      rd_last = p; n_rd++;
      addr_log.push_back(rd_addr);
    end
    if (coef_we) begin
      if (n_we == 0) we_first = p;
      we_last = p; n_we++;
      wr_log.push_back({coef_ch, coef_tap, coef_data});
    end
    if (coef_mirr) begin
      if (n_mirr == 0) mirr_first = p;
      mirr_last = p; n_mirr++;
      div_at_mirr = null_div;
    end
    if (done) begin
      n_done++; done_at = p; busy_at_done = busy;
    end
  endtask

  task automatic quiet_inputs();
    start = 1'b0; clr_err = 1'b0; rst = 1'b0; sample_valid = 1'b0;
  endtask

  // One load request issued in the current period k.
  //   vmode 0: sample_valid high from relative cycle vparam on; 1: random.
  //   ovr_a/ovr_b: extra starts while busy (ovr_b also pulses clr_err).
  //   rst_at: relative cycle of a reset pulse (-1 = none).
  task automatic run_load(input int bank, input int div, input int vmode, input int vparam,
                          input int ovr_a, input int ovr_b, input int rst_at, input bit commit);
    bit   vpat [0:LIM];
    int   k, m_rel, b1;
    logic [20:0] exp_w;
    for (int r = 0; r <= LIM; r++) vpat[r] = (vmode == 0) ? (r >= vparam) : ($urandom_range(0, 2) == 0);
    vpat[60] = 1'b1;
    m_rel = -1;
    for (int r = NW + 2; r <= LIM; r++) if (m_rel < 0 && vpat[r]) m_rel = r;
    clear_stats();
    k = p;
    b1 = 0;
    for (int r = 0; r <= LIM; r++) begin
      start        = (r == 0) || (r == ovr_a) || (r == ovr_b);
      clr_err      = (r == ovr_b);
      rst          = (r == rst_at);
      sample_valid = vpat[r];
      bank_sel     = (r == 0) ? 2'(bank) : 2'($urandom_range(0, 3));
      div_in       = (r == 0) ? 8'(div) : 8'($urandom_range(0, 255));
      tick();
      if (r == 0) b1 = int'(busy);
      if (commit && n_done > 0) break;
      if (!commit && r >= rst_at + 40) break;
    end
    quiet_inputs();
    tick();
    if (commit) begin
      chk("busy_after_start", b1, 1);
      chk("rd_count", n_rd, NW);
      chk("rd_first", rd_first, k + 1);
      chk("rd_last", rd_last, k + NW);
      for (int i = 0; i < NW && i < addr_log.size(); i++)
        chk($sformatf("rd_addr[%0d]", i), addr_log[i], bank * NW + i);
      if (addr_log.size() > 0) chk("rd_addr_final", addr_log[addr_log.size() - 1], bank * NW + NW - 1);
      chk("we_count", n_we, NW);
      chk("we_first", we_first, k + 2);
      chk("we_last", we_last, k + NW + 1);
      for (int i = 0; i < NW && i < wr_log.size(); i++) begin
        exp_w = {2'(i / NT), 3'(i % NT), mem[bank * NW + i]};
        chk($sformatf("write[%0d]", i), wr_log[i], exp_w);
      end
      chk("mirr_first", mirr_first, k + NW + 2);
      chk("mirr_last", mirr_last, k + m_rel);
      chk("mirr_count", n_mirr, m_rel - NW - 1);
      chk("div_during_mirr", div_at_mirr, exp_div);
      chk("done_count", n_done, 1);
      chk("done_at", done_at, k + m_rel + 1);
      chk("busy_at_done", busy_at_done, 0);
      exp_div = 8'(div);
      chk("null_div_new", null_div, exp_div);
    end else begin
      chk("rst_rd_count", n_rd, rst_at);
      chk("rst_we_count", n_we, rst_at - 1);
      chk("rst_no_mirr", n_mirr, 0);
      chk("rst_no_done", n_done, 0);
      exp_div = 8'h00;
      chk("rst_null_div", null_div, exp_div);
      chk("rst_busy", busy, 0);
    end
    if (ovr_a >= 0) chk("overrun_set", overrun, 1);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
    quiet_inputs();
    rst = 1'b1;
    bank_sel = 2'd0;
    div_in = 8'd0;
    repeat (3) tick();
    chk("reset_rd_en", rd_en, 0);
    chk("reset_rd_addr", rd_addr, 0);
    chk("reset_coef_we", coef_we, 0);
    chk("reset_coef_ch", coef_ch, 0);
    chk("reset_coef_tap", coef_tap, 0);
    chk("reset_coef_data", coef_data, 0);
    chk("reset_coef_mirr", coef_mirr, 0);
    chk("reset_null_div", null_div, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_overrun", overrun, 0);
    exp_div = 8'h00;
    rst = 1'b0;
    tick();

    // Basic load, valid always high.
    run_load(1, 5, 0, 0, -1, -1, -1, 1'b1);
    // Valid held low for 10 cycles after ARM entry.
    run_load(0, 9, 0, NW + 12, -1, -1, -1, 1'b1);
    // Overrun, plus start and clr_err together (set must win).
    run_load(2, 3, 0, 0, 5, 7, -1, 1'b1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("overrun_cleared", overrun, 0);
    // Reset mid-load: no commit.
    run_load(3, 7, 0, 0, -1, -1, 10, 1'b0);
    // Last bank, then back-to-back load the cycle after done.
    run_load(3, 11, 0, 0, -1, -1, -1, 1'b1);
    run_load(2, 13, 0, 0, -1, -1, -1, 1'b1);
    chk("no_overrun_b2b", overrun, 0);
    // Randomized banks, dividers and valid patterns.
    for (int j = 0; j < 3; j++)
      run_load($urandom_range(0, 3), $urandom_range(0, 255), 1, 0, -1, -1, -1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
